// File: rtl/ha_bist_checker.sv
// On-chip BIST checker for a 1-bit half adder: sweeps a/b through 00,01,10,11 and checks sum/carry.
// Optional HA_BIST_FAIL_CAPTURE_EN adds fail_vec/fail_vld capture of the first mismatching vector.
module ha_bist_checker #(
  parameter int NUM_PASSES = 1,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             sum_i,
  input  logic             carry_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef HA_BIST_FAIL_CAPTURE_EN
  ,
  output logic [1:0]       fail_vec,
  output logic [0:0]       fail_vld
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  state_t           state, state_next;
  logic [1:0]       vec;
  logic [SW-1:0]    settle;
  logic [PW-1:0]    pass_cnt;
  logic             mismatch, settled, last_pass;
  logic [ERR_W-1:0] err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_o        = 1'b0;
    b_o        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    settled    = (settle == SW'(SETTLE_CYC - 1));
    last_pass  = (pass_cnt == PW'(NUM_PASSES - 1));
    mismatch   = (sum_i != (vec[1] ^ vec[0])) || (carry_i != (vec[1] & vec[0]));
    err_next   = err_cnt;
    // Saturating increment; the final-sample result must be visible to pass in DONE
    if (state == SAMPLE && mismatch && err_cnt != '1) err_next = err_cnt + ERR_W'(1);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        a_o = vec[1];
        b_o = vec[0];
        if (settled) state_next = SAMPLE;
      end
      SAMPLE: begin
        a_o = vec[1];
        b_o = vec[0];
        state_next = (vec == 2'd3 && last_pass) ? DONE : DRIVE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      settle   <= '0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
`ifdef HA_BIST_FAIL_CAPTURE_EN
      fail_vec <= '0;
      fail_vld <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec      <= '0;
            settle   <= '0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
`ifdef HA_BIST_FAIL_CAPTURE_EN
            fail_vec <= '0;
            fail_vld <= '0;
`endif
          end
        end
        DRIVE: settle <= settled ? '0 : settle + SW'(1);
        SAMPLE: begin
          err_cnt <= err_next;
`ifdef HA_BIST_FAIL_CAPTURE_EN
          if (mismatch && !fail_vld[0]) begin
            fail_vec <= vec;
            fail_vld <= 1'b1;
          end
`endif
          if (vec == 2'd3) begin
            vec <= '0;
            if (last_pass) pass <= (err_next == '0);
            else           pass_cnt <= pass_cnt + PW'(1);
          end else begin
            vec <= vec + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
